// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU data-memory path: state and op encodings, bus widths.
package cpu_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  typedef enum logic {
    MEM_OP_RD = 1'b0,
    MEM_OP_WR = 1'b1
  } mem_op_e;

endpackage

// File: rtl/mem_byte_bank.sv
// Byte-wide storage with a big-endian 4-lane word read and a word write enable.
// The array has no reset. Addresses are assumed word-aligned by the caller.
module mem_byte_bank
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 128,
  localparam int unsigned AW = $clog2(DEPTH_BYTES)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [BYTE_W-1:0] mem_q [DEPTH_BYTES];

  // Lane addresses; OR-ing is addition because the base is word-aligned.
  logic [AW-1:0] a0, a1, a2, a3;
  assign a0 = addr_i;
  assign a1 = addr_i | AW'(1);
  assign a2 = addr_i | AW'(2);
  assign a3 = addr_i | AW'(3);

  // Combinational big-endian word read: lowest address is the most significant byte.
  always_comb begin
    rdata_o = {mem_q[a0], mem_q[a1], mem_q[a2], mem_q[a3]};
  end

  // Word write, committed only when the FSM asserts its commit strobe.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[a0] <= wdata_i[31:24];
      mem_q[a1] <= wdata_i[23:16];
      mem_q[a2] <= wdata_i[15:8];
      mem_q[a3] <= wdata_i[7:0];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: captures a read/write request, waits a programmable
// number of cycles, then completes with a registered mReady (and mErr for rejected accesses).
module data_mem_responder
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 128,  // power of two, at least 8
  parameter int unsigned WAIT_CYCLES = 2,    // 0..15
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              mRD,
  input  logic              mWR,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [WORD_W-1:0] DataIn,
  output logic [WORD_W-1:0] DataOut,
  output logic              mReady,
  output logic              mErr,
  output logic              Busy
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);

  mem_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  mem_op_e           op_q, op_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [WORD_W-1:0] dout_q, dout_d;
  logic              ready_q, ready_d;
  logic              merr_q, merr_d;
  logic              busy_q, busy_d;
  logic              enter_done;
  logic              commit;
  logic              req_err;
  logic [WORD_W-1:0] rdata;

  // Rejected accesses: both strobes, misaligned, or beyond the array (no wrap-around).
  always_comb begin
    req_err = (mRD & mWR) | (DAddr[1:0] != 2'b00) | (DAddr >= ADDR_W'(DEPTH_BYTES));
  end

  // Next-state, capture and completion logic. The *_d request fields double as the
  // effective access, so a zero-wait access completes straight from the inputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    dout_d     = dout_q;
    ready_d    = 1'b0;
    merr_d     = 1'b0;
    busy_d     = busy_q;
    enter_done = 1'b0;

    unique case (state_q)
      MEM_IDLE: begin
        if (mRD | mWR) begin
          op_d    = (mWR & ~mRD) ? MEM_OP_WR : MEM_OP_RD;
          addr_d  = DAddr[AW-1:0];
          wdata_d = DataIn;
          err_d   = req_err;
          busy_d  = 1'b1;
          cnt_d   = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            enter_done = 1'b1;
          end else begin
            state_d = MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        if (!mRD && !mWR) begin
          // Initiator withdrew: abandon the access silently.
          state_d = MEM_IDLE;
          busy_d  = 1'b0;
          cnt_d   = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          enter_done = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      MEM_DONE: begin
        // Always pass through IDLE so a held request is re-sampled there.
        state_d = MEM_IDLE;
      end
      default: begin
        state_d = MEM_IDLE;
      end
    endcase

    if (enter_done) begin
      state_d = MEM_DONE;
      busy_d  = 1'b0;
      cnt_d   = 4'd0;
      ready_d = 1'b1;
      merr_d  = err_d;
      if (!err_d && (op_d == MEM_OP_RD)) begin
        dout_d = rdata;
      end
    end
  end

  // Writes land on the edge that enters DONE, never earlier.
  assign commit = enter_done & ~err_d & (op_d == MEM_OP_WR);

  // State, capture and registered-output flops.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= MEM_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= MEM_OP_RD;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      dout_q  <= '0;
      ready_q <= 1'b0;
      merr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
      merr_q  <= merr_d;
      busy_q  <= busy_d;
    end
  end

  mem_byte_bank #(
    .DEPTH_BYTES(DEPTH_BYTES)
  ) u_bank (
    .clk_i  (CLK),
    .we_i   (commit),
    .addr_i (addr_d),
    .wdata_i(wdata_d),
    .rdata_o(rdata)
  );

  assign DataOut = dout_q;
  assign mReady  = ready_q;
  assign mErr    = merr_q;
  assign Busy    = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait states, one with none.
module tb_data_mem_responder;

  logic        CLK = 1'b0;
  logic        Reset;

  // Instance with WAIT_CYCLES=2
  logic        rd_a, wr_a;
  logic [31:0] addr_a, din_a, dout_a;
  logic        rdy_a, err_a, busy_a;

  // Instance with WAIT_CYCLES=0
  logic        rd_z, wr_z;
  logic [31:0] addr_z, din_z, dout_z;
  logic        rdy_z, err_z, busy_z;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  data_mem_responder #(
    .DEPTH_BYTES(128),
    .WAIT_CYCLES(2),
    .ADDR_W     (32)
  ) dut (
    .CLK    (CLK),
    .Reset  (Reset),
    .mRD    (rd_a),
    .mWR    (wr_a),
    .DAddr  (addr_a),
    .DataIn (din_a),
    .DataOut(dout_a),
    .mReady (rdy_a),
    .mErr   (err_a),
    .Busy   (busy_a)
  );

  data_mem_responder #(
    .DEPTH_BYTES(128),
    .WAIT_CYCLES(0),
    .ADDR_W     (32)
  ) dut_z (
    .CLK    (CLK),
    .Reset  (Reset),
    .mRD    (rd_z),
    .mWR    (wr_z),
    .DAddr  (addr_z),
    .DataIn (din_z),
    .DataOut(dout_z),
    .mReady (rdy_z),
    .mErr   (err_z),
    .Busy   (busy_z)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bit zero, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (zero) begin
      rd_z = rd; wr_z = wr; addr_z = a; din_z = d;
    end else begin
      rd_a = rd; wr_a = wr; addr_a = a; din_a = d;
    end
  endtask

  // Issue one request, wait (bounded) for mReady, drop the request, return to IDLE.
  // lat counts edges from the request being presented to mReady being seen; 0 = timeout.
  task automatic access(input bit zero, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic err, output logic [31:0] dout);
    lat  = 0;
    err  = 1'b0;
    dout = 32'h0;
    drive(zero, rd, wr, a, d);
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (zero ? rdy_z : rdy_a) begin
        lat  = k;
        err  = zero ? err_z : err_a;
        dout = zero ? dout_z : dout_a;
        break;
      end
    end
    drive(zero, 1'b0, 1'b0, a, d);
    tick();
  endtask

  int          lat;
  logic        err;
  logic [31:0] dout;
  int          sum;
  int          pulses;
  int          last;

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    Reset = 1'b0;
    #1;
    check("reset DataOut", dout_a, 32'h0);
    check("reset mReady", {31'h0, rdy_a}, 32'h0);
    check("reset mErr", {31'h0, err_a}, 32'h0);
    check("reset Busy", {31'h0, busy_a}, 32'h0);
    repeat (2) @(posedge CLK);
    #3 Reset = 1'b1;
    tick();

    // Write then read back at 0x08
    access(1'b0, 1'b0, 1'b1, 32'h08, 32'h1234_5678, lat, err, dout);
    check("wr08 latency", lat, 3);
    check("wr08 mErr", {31'h0, err}, 32'h0);
    check("mReady one cycle", {31'h0, rdy_a}, 32'h0);
    access(1'b0, 1'b1, 1'b0, 32'h08, 32'h0, lat, err, dout);
    check("rd08 latency", lat, 3);
    check("rd08 data", dout, 32'h1234_5678);
    check("rd08 mErr", {31'h0, err}, 32'h0);

    // Misaligned and out-of-range reads keep the old DataOut
    access(1'b0, 1'b1, 1'b0, 32'h06, 32'h0, lat, err, dout);
    check("rd06 latency", lat, 3);
    check("rd06 mErr", {31'h0, err}, 32'h1);
    check("rd06 DataOut held", dout, 32'h1234_5678);
    access(1'b0, 1'b1, 1'b0, 32'h80, 32'h0, lat, err, dout);
    check("rd80 mErr", {31'h0, err}, 32'h1);
    check("rd80 DataOut held", dout, 32'h1234_5678);

    // Aborted write leaves old contents
    access(1'b0, 1'b0, 1'b1, 32'h10, 32'h1111_1111, lat, err, dout);
    drive(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    tick();
    check("abort Busy high", {31'h0, busy_a}, 32'h1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h10, 32'hDEAD_BEEF);
    tick();
    check("abort Busy low", {31'h0, busy_a}, 32'h0);
    sum = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      sum += int'(rdy_a);
    end
    check("abort no mReady", sum, 0);
    access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, lat, err, dout);
    check("rd10 after abort", dout, 32'h1111_1111);

    // Asynchronous reset in WAIT discards a pending write
    access(1'b0, 1'b0, 1'b1, 32'h14, 32'hAAAA_5555, lat, err, dout);
    drive(1'b0, 1'b0, 1'b1, 32'h14, 32'hCAFE_F00D);
    tick();
    tick();
    #2 Reset = 1'b0;
    #1;
    check("async rst Busy", {31'h0, busy_a}, 32'h0);
    check("async rst DataOut", dout_a, 32'h0);
    check("async rst mReady", {31'h0, rdy_a}, 32'h0);
    check("async rst mErr", {31'h0, err_a}, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #2 Reset = 1'b1;
    tick();
    access(1'b0, 1'b1, 1'b0, 32'h14, 32'h0, lat, err, dout);
    check("rd14 after reset", dout, 32'hAAAA_5555);
    check("rd14 latency", lat, 3);

    // Both strobes high: error with full wait, memory untouched
    access(1'b0, 1'b1, 1'b1, 32'h14, 32'h0BAD_0BAD, lat, err, dout);
    check("both latency", lat, 3);
    check("both mErr", {31'h0, err}, 32'h1);
    check("both DataOut held", dout, 32'hAAAA_5555);
    access(1'b0, 1'b1, 1'b0, 32'h14, 32'h0, lat, err, dout);
    check("rd14 after both", dout, 32'hAAAA_5555);

    // Zero-wait instance
    access(1'b1, 1'b0, 1'b1, 32'h04, 32'h0102_0304, lat, err, dout);
    check("w0 wr latency", lat, 1);
    check("w0 wr mErr", {31'h0, err}, 32'h0);
    access(1'b1, 1'b1, 1'b0, 32'h04, 32'h0, lat, err, dout);
    check("w0 rd latency", lat, 1);
    check("w0 rd data", dout, 32'h0102_0304);

    // Request held high: back-to-back reads every WAIT_CYCLES+2 cycles
    drive(1'b0, 1'b1, 1'b0, 32'h08, 32'h0);
    pulses = 0;
    last   = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (rdy_a) begin
        pulses++;
        if (pulses == 1) check("b2b first", k, 3);
        else check("b2b gap", k - last, 4);
        check("b2b data", dout_a, 32'h1234_5678);
        last = k;
        if (pulses == 4) begin
          drive(1'b0, 1'b0, 1'b0, 32'h08, 32'h0);
          break;
        end
      end
    end
    check("b2b pulses", pulses, 4);
    tick();
    tick();
    check("b2b idle Busy", {31'h0, busy_a}, 32'h0);
    check("b2b idle mReady", {31'h0, rdy_a}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
